adc_capture_engine: RTL and testbench

Parametrised successor to the fixed 8-bit ADC-to-SPI path. It decimates a sample stream and arms on an SPI command. It triggers on a programmable level or edge, and stores pre- and post-trigger samples in a circular buffer. The stored record is then streamed out byte-serially through the SPI slave's byte interface. It sits between the ADC capture front end (clk-domain sample strobe) and spi_slaver, in the sys_clk domain.

---
 rtl/adc_capture_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_adc_capture_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_engine.sv
// -----------------------------------------------------------------------------
// adc_capture_engine
//
// Decimating ADC capture engine with a programmable level/edge trigger and a
// circular pre/post-trigger record buffer. The finished record is read out
// byte-serially through the SPI slave's byte interface.
//
// Ports
//   clk           system clock (only clock)
//   reset         synchronous, active-high reset
//   sample_valid  one-cycle strobe qualifying sample_data
//   sample_data   unsigned ADC sample, DATA_W bits
//   decim         keep 1 of every decim+1 valid samples (latched at ARM)
//   trig_mode     0 rising, 1 falling, 2/3 immediate (latched at ARM)
//   trig_level    trigger threshold (latched at ARM)
//   rxd_flag      one-cycle strobe: rxd_data holds a received command byte
//   rxd_data      command byte: 0x01 ARM, 0x02 ABORT, 0x03 NEXT
//   txd_data      readout byte in DONE, status byte {5'b0, state} otherwise
//   busy          high in PRE, WAIT_TRIG and POST
//   done          high in DONE
//   triggered     one-cycle pulse on the trigger sample
//
// Handshake: rxd_flag and sample_valid are qualifiers, not valid/ready pairs.
// Each is a single-cycle strobe that is consumed in the cycle it is high; the
// engine never back-pressures. A command (ARM/ABORT) in the same cycle as a
// kept sample wins and the sample is discarded.
// -----------------------------------------------------------------------------
module adc_capture_engine #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 1024,
    parameter int PRE_SAMPLES = 256,
    parameter int DEC_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DEC_W-1:0]  decim,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              rxd_flag,
    input  logic [7:0]        rxd_data,
    output logic [7:0]        txd_data,
    output logic              busy,
    output logic              done,
    output logic              triggered
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BYTES  = (DATA_W + 7) / 8;
    localparam int BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  PRE_N     = CNT_W'(PRE_SAMPLES);
    localparam logic [CNT_W-1:0]  POST_N    = CNT_W'(DEPTH - PRE_SAMPLES);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_SAMPLES);
    localparam logic [BSEL_W-1:0] LAST_BYTE = BSEL_W'(BYTES - 1);

    localparam logic [7:0] CMD_ARM   = 8'h01;
    localparam logic [7:0] CMD_ABORT = 8'h02;
    localparam logic [7:0] CMD_NEXT  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [DEC_W-1:0]    decim_q;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   level_q;
    logic [DEC_W-1:0]    dec_cnt_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]    pre_cnt_q;
    logic [CNT_W-1:0]    post_cnt_q;
    logic [DATA_W-1:0]   prev_q;
    logic                have_prev_q;
    logic [ADDR_W-1:0]   trig_addr_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [BSEL_W-1:0]   rd_byte_q;
    logic                busy_q;
    logic                done_q;
    logic                triggered_q;

    // Read pipeline: RAM output register, then byte-select output register.
    logic [DATA_W-1:0]   ram_q;
    logic [BSEL_W-1:0]   byte_d1_q;
    logic [7:0]          rd_out_q;
    logic [BYTES*8-1:0]  ram_pad;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic cmd_arm, cmd_abort, cmd_next;
    logic capturing, kept, we, hit, fire;

    assign cmd_arm   = rxd_flag && (rxd_data == CMD_ARM);
    assign cmd_abort = rxd_flag && (rxd_data == CMD_ABORT);
    assign cmd_next  = rxd_flag && (rxd_data == CMD_NEXT);

    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

    // The decimation phase is aligned so the first valid sample after ARM is
    // kept, then every (decim+1)-th after it.
    assign kept = sample_valid && capturing && (dec_cnt_q == '0) && !cmd_arm && !cmd_abort;

    // In PRE a kept sample is stored only while the pre-trigger quota is open;
    // with PRE_SAMPLES = 0 nothing is stored before WAIT_TRIG.
    assign we = kept && ((state_q == S_WAIT) || (state_q == S_POST) ||
                         ((state_q == S_PRE) && (pre_cnt_q != PRE_N)));

    always_comb begin
        hit = 1'b0;
        case (mode_q)
            2'd0:    hit = have_prev_q && (prev_q < level_q) && (sample_data >= level_q);
            2'd1:    hit = have_prev_q && (prev_q > level_q) && (sample_data <= level_q);
            default: hit = 1'b1;
        endcase
    end

    assign fire = kept && (state_q == S_WAIT) && hit;

    // Capture / readout FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            decim_q     <= '0;
            mode_q      <= '0;
            level_q     <= '0;
            dec_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            trig_addr_q <= '0;
            rd_addr_q   <= '0;
            rd_byte_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            triggered_q <= 1'b0;

            if (sample_valid && capturing) begin
                dec_cnt_q <= (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + 1'b1;
            end
            if (we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (kept) begin
                prev_q      <= sample_data;
                have_prev_q <= 1'b1;
            end

            if (cmd_arm) begin
                decim_q     <= decim;
                mode_q      <= trig_mode;
                level_q     <= trig_level;
                dec_cnt_q   <= '0;
                wr_ptr_q    <= '0;
                pre_cnt_q   <= '0;
                post_cnt_q  <= '0;
                have_prev_q <= 1'b0;
                rd_addr_q   <= '0;
                rd_byte_q   <= '0;
                state_q     <= S_PRE;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
            end else if (cmd_abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_PRE: begin
                        if (PRE_N == '0) begin
                            state_q <= S_WAIT;
                        end else if (kept) begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                            if (pre_cnt_q + 1'b1 == PRE_N) begin
                                state_q <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (fire) begin
                            triggered_q <= 1'b1;
                            trig_addr_q <= wr_ptr_q;
                            post_cnt_q  <= CNT_W'(1);
                            if (POST_N == CNT_W'(1)) begin
                                // Single-sample post window: the trigger sample
                                // completes the record.
                                state_q   <= S_DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                rd_addr_q <= wr_ptr_q - PRE_OFS;
                                rd_byte_q <= '0;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (kept) begin
                            post_cnt_q <= post_cnt_q + 1'b1;
                            if (post_cnt_q + 1'b1 == POST_N) begin
                                state_q   <= S_DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                rd_addr_q <= trig_addr_q - PRE_OFS;
                                rd_byte_q <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        // Address wraps naturally modulo DEPTH, so the sample
                        // after rd_start + DEPTH - 1 is rd_start again.
                        if (cmd_next) begin
                            if (rd_byte_q == LAST_BYTE) begin
                                rd_byte_q <= '0;
                                rd_addr_q <= rd_addr_q + 1'b1;
                            end else begin
                                rd_byte_q <= rd_byte_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Inferred block RAM: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr_q] <= sample_data;
        end
        ram_q <= mem[rd_addr_q];
    end

    // Zero-extend to a whole number of bytes so unused upper bits read as 0.
    always_comb begin
        ram_pad = '0;
        ram_pad[DATA_W-1:0] = ram_q;
    end

    // byte_d1_q keeps the byte index aligned with the RAM output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_d1_q <= '0;
            rd_out_q  <= '0;
        end else begin
            byte_d1_q <= rd_byte_q;
            rd_out_q  <= ram_pad[8*byte_d1_q +: 8];
        end
    end

    assign txd_data  = (state_q == S_DONE) ? rd_out_q : {5'b0, state_q};
    assign busy      = busy_q;
    assign done      = done_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_adc_capture_engine.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_engine
//
// Directed bench for adc_capture_engine. Instance A: DATA_W=8, DEPTH=16,
// PRE_SAMPLES=4. Instance B: DATA_W=12, DEPTH=4, PRE_SAMPLES=0. Expected
// values are hand-computed from the capture/readout rules.
// -----------------------------------------------------------------------------
module tb_adc_capture_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Instance A
    logic        a_valid = 1'b0;
    logic [7:0]  a_data  = '0;
    logic [7:0]  a_decim = '0;
    logic [1:0]  a_mode  = '0;
    logic [7:0]  a_level = '0;
    logic        a_flag  = 1'b0;
    logic [7:0]  a_rxd   = '0;
    logic [7:0]  a_txd;
    logic        a_busy, a_done, a_triggered;

    // Instance B
    logic        b_valid = 1'b0;
    logic [11:0] b_data  = '0;
    logic [3:0]  b_decim = '0;
    logic [1:0]  b_mode  = '0;
    logic [11:0] b_level = '0;
    logic        b_flag  = 1'b0;
    logic [7:0]  b_rxd   = '0;
    logic [7:0]  b_txd;
    logic        b_busy, b_done, b_triggered;

    int checks = 0;
    int failures = 0;
    int trig_count = 0;
    logic [15:0] trig_val = '0;

    always #5 clk = ~clk;

    adc_capture_engine #(.DATA_W(8), .DEPTH(16), .PRE_SAMPLES(4), .DEC_W(8)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (a_valid),
        .sample_data  (a_data),
        .decim        (a_decim),
        .trig_mode    (a_mode),
        .trig_level   (a_level),
        .rxd_flag     (a_flag),
        .rxd_data     (a_rxd),
        .txd_data     (a_txd),
        .busy         (a_busy),
        .done         (a_done),
        .triggered    (a_triggered)
    );

    adc_capture_engine #(.DATA_W(12), .DEPTH(4), .PRE_SAMPLES(0), .DEC_W(4)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (b_valid),
        .sample_data  (b_data),
        .decim        (b_decim),
        .trig_mode    (b_mode),
        .trig_level   (b_level),
        .rxd_flag     (b_flag),
        .rxd_data     (b_rxd),
        .txd_data     (b_txd),
        .busy         (b_busy),
        .done         (b_done),
        .triggered    (b_triggered)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle sample strobe; records the sample value if triggered pulses.
    task automatic send_sample(input bit to_b, input logic [15:0] d);
        @(negedge clk);
        if (to_b) begin
            b_valid = 1'b1;
            b_data  = d[11:0];
        end else begin
            a_valid = 1'b1;
            a_data  = d[7:0];
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (to_b ? b_triggered : a_triggered) begin
            trig_count++;
            trig_val = d;
        end
    endtask

    // One-cycle command strobe, optionally with a coincident sample.
    task automatic send_cmd(input bit to_b, input logic [7:0] cmd,
                            input bit with_sample, input logic [15:0] d);
        @(negedge clk);
        if (to_b) begin
            b_flag = 1'b1;
            b_rxd  = cmd;
            b_valid = with_sample;
            b_data  = d[11:0];
        end else begin
            a_flag = 1'b1;
            a_rxd  = cmd;
            a_valid = with_sample;
            a_data  = d[7:0];
        end
        @(posedge clk);
        #1;
        a_flag = 1'b0;
        b_flag = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (to_b ? b_triggered : a_triggered) begin
            trig_count++;
            trig_val = d;
        end
    endtask

    // Check the current readout byte of A against exp, then step with NEXT.
    task automatic read_a(input string tag, input logic [7:0] exp);
        check_eq(tag, {24'b0, a_txd}, {24'b0, exp});
        send_cmd(1'b0, 8'h03, 1'b0, 16'h0);
        wait_cycles(2);
    endtask

    task automatic read_b(input string tag, input logic [7:0] exp);
        check_eq(tag, {24'b0, b_txd}, {24'b0, exp});
        send_cmd(1'b1, 8'h03, 1'b0, 16'h0);
        wait_cycles(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e;

        // ---------------- reset ----------------
        reset = 1'b1;
        wait_cycles(3);
        check_eq("rst_status", {24'b0, a_txd}, 32'h0);
        check_eq("rst_busy", {31'b0, a_busy}, 32'h0);
        check_eq("rst_done", {31'b0, a_done}, 32'h0);
        check_eq("rst_trig", {31'b0, a_triggered}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(1);

        // ---------------- rising ramp, readout and wrap ----------------
        a_decim = 8'd0; a_mode = 2'd0; a_level = 8'h80;
        send_cmd(1'b0, 8'h01, 1'b0, 16'h0);
        check_eq("arm_status", {24'b0, a_txd}, 32'h1);
        check_eq("arm_busy", {31'b0, a_busy}, 32'h1);
        trig_count = 0;
        for (int i = 0; i < 20; i++) begin
            send_sample(1'b0, 16'((i * 16) & 8'hFF));
            if (i == 8) check_eq("rise_post_status", {24'b0, a_txd}, 32'h3);
        end
        check_eq("rise_trig_count", trig_count, 32'd1);
        check_eq("rise_trig_val", {16'b0, trig_val}, 32'h80);
        check_eq("rise_done", {31'b0, a_done}, 32'h1);
        check_eq("rise_busy_done", {31'b0, a_busy}, 32'h0);
        wait_cycles(2);
        for (int k = 0; k < 16; k++) begin
            e = 8'h40 + 8'(k * 16);
            read_a($sformatf("rise_rd%0d", k), e);
        end
        check_eq("rise_rd_wrap", {24'b0, a_txd}, 32'h40);

        // ---------------- ARM in DONE, falling edge ----------------
        a_mode = 2'd1; a_level = 8'h40;
        send_cmd(1'b0, 8'h01, 1'b0, 16'h0);
        check_eq("rearm_status", {24'b0, a_txd}, 32'h1);
        check_eq("rearm_done", {31'b0, a_done}, 32'h0);
        trig_count = 0;
        for (int i = 0; i < 4; i++) send_sample(1'b0, 16'h60);
        send_sample(1'b0, 16'h50);
        check_eq("fall_no_early", trig_count, 32'd0);
        send_sample(1'b0, 16'h40);
        check_eq("fall_trig_count", trig_count, 32'd1);
        check_eq("fall_trig_val", {16'b0, trig_val}, 32'h40);
        check_eq("fall_post_status", {24'b0, a_txd}, 32'h3);

        // ---------------- ABORT during POST ----------------
        send_cmd(1'b0, 8'h02, 1'b0, 16'h0);
        check_eq("abort_status", {24'b0, a_txd}, 32'h0);
        check_eq("abort_busy", {31'b0, a_busy}, 32'h0);

        // ---------------- constant level never fires ----------------
        send_cmd(1'b0, 8'h01, 1'b0, 16'h0);
        trig_count = 0;
        for (int i = 0; i < 20; i++) send_sample(1'b0, 16'h40);
        check_eq("const_trig_count", trig_count, 32'd0);
        check_eq("const_status", {24'b0, a_txd}, 32'h2);

        // ---------------- reset mid-WAIT_TRIG ----------------
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_status", {24'b0, a_txd}, 32'h0);
        check_eq("midrst_busy", {31'b0, a_busy}, 32'h0);
        check_eq("midrst_done", {31'b0, a_done}, 32'h0);
        reset = 1'b0;

        // ---------------- ARM coinciding with a kept sample ----------------
        a_decim = 8'd0; a_mode = 2'd2;
        send_cmd(1'b0, 8'h01, 1'b0, 16'h0);
        send_sample(1'b0, 16'h11);
        send_sample(1'b0, 16'h22);
        send_cmd(1'b0, 8'h01, 1'b1, 16'hEE);
        trig_count = 0;
        for (int i = 1; i <= 16; i++) send_sample(1'b0, 16'(i));
        check_eq("coinc_trig_val", {16'b0, trig_val}, 32'h05);
        check_eq("coinc_done", {31'b0, a_done}, 32'h1);
        wait_cycles(2);
        for (int k = 0; k < 4; k++) read_a($sformatf("coinc_rd%0d", k), 8'(k + 1));

        // ---------------- decimation by 3, immediate trigger ----------------
        a_decim = 8'd2; a_mode = 2'd2;
        send_cmd(1'b0, 8'h01, 1'b0, 16'h0);
        trig_count = 0;
        for (int i = 0; i < 48; i++) send_sample(1'b0, 16'(i));
        check_eq("dec_trig_count", trig_count, 32'd1);
        check_eq("dec_trig_val", {16'b0, trig_val}, 32'd12);
        check_eq("dec_done", {31'b0, a_done}, 32'h1);
        wait_cycles(2);
        for (int k = 0; k < 4; k++) read_a($sformatf("dec_rd%0d", k), 8'(k * 3));

        // ---------------- 12-bit samples, PRE_SAMPLES = 0 ----------------
        b_decim = 4'd0; b_mode = 2'd2; b_level = 12'h0;
        send_cmd(1'b1, 8'h01, 1'b0, 16'h0);
        wait_cycles(1);
        check_eq("b_wait_status", {24'b0, b_txd}, 32'h2);
        trig_count = 0;
        send_sample(1'b1, 16'h0ABC);
        send_sample(1'b1, 16'h0123);
        send_sample(1'b1, 16'h0456);
        send_sample(1'b1, 16'h0789);
        check_eq("b_trig_val", {16'b0, trig_val}, 32'hABC);
        check_eq("b_done", {31'b0, b_done}, 32'h1);
        wait_cycles(2);
        read_b("b_rd0_lo", 8'hBC);
        read_b("b_rd0_hi", 8'h0A);
        read_b("b_rd1_lo", 8'h23);
        read_b("b_rd1_hi", 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
